// File: rtl/tiny_loader_pkg.sv
// Shared types and constants for the tiny processor program loader.
// Optional checksum stage: TINY_LOADER_CHECKSUM_EN.
package tiny_loader_pkg;

  localparam int ADDR_W_DEF = 4;
  localparam int NIBBLE_W   = 4;
  localparam int BYTE_W     = 8;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HI   = 3'd1,
    LO   = 3'd2,
    WR   = 3'd3,
    CK   = 3'd4,
    DN   = 3'd5
  } state_t;

endpackage

// File: rtl/tiny_prog_ram.sv
// Program store: flop array, async clear, sync write, async read.
// Clearing on reset guarantees no partial program survives an aborted load.
module tiny_prog_ram
  import tiny_loader_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [BYTE_W-1:0] wdata,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [BYTE_W-1:0] rd_data
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [BYTE_W-1:0] mem [DEPTH];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/tiny_prog_loader.sv
// Nibble-stream program loader; holds the CPU while filling program RAM.
// Checksum byte and load_err exist only with TINY_LOADER_CHECKSUM_EN.
module tiny_prog_loader
  import tiny_loader_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                load_start,
  input  logic                nib_valid,
  input  logic [NIBBLE_W-1:0] nib_data,
  output logic                nib_ready,
  output logic                load_busy,
  output logic                load_done,
  output logic                load_err,
  output logic                cpu_hold,
  input  logic [ADDR_W-1:0]   rd_addr,
  output logic [BYTE_W-1:0]   rd_data
);

  state_t              state;
  state_t              nstate;
  logic [ADDR_W-1:0]   addr;
  logic [NIBBLE_W-1:0] hi;
  logic [NIBBLE_W-1:0] lo;
  logic                xfer;
  logic                last;
  logic                ck_last;

  assign xfer = nib_valid && nib_ready;
  assign last = (addr == '1);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      addr  <= '0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      state <= nstate;
      if (state == IDLE && load_start) addr <= '0;
      if (state == HI && xfer) hi <= nib_data;
      if (state == LO && xfer) lo <= nib_data;
      if (state == WR && !last) addr <= addr + ADDR_W'(1);
    end
  end

`ifdef TINY_LOADER_CHECKSUM_EN
  logic [BYTE_W-1:0]   sum;
  logic [BYTE_W-1:0]   total;
  logic [NIBBLE_W-1:0] chk_hi;
  logic                ck_lo;
  logic                err;

  assign total   = sum + {chk_hi, nib_data};
  assign ck_last = ck_lo;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sum    <= '0;
      chk_hi <= '0;
      ck_lo  <= 1'b0;
      err    <= 1'b0;
    end else begin
      if (state == IDLE && load_start) begin
        sum   <= '0;
        ck_lo <= 1'b0;
        err   <= 1'b0;
      end
      if (state == WR) sum <= sum + {hi, lo};
      if (state == CK && xfer) begin
        if (!ck_lo) begin
          chk_hi <= nib_data;
          ck_lo  <= 1'b1;
        end else begin
          ck_lo <= 1'b0;
          err   <= (total != '0);
        end
      end
    end
  end

  assign load_err = err;
`else
  assign ck_last  = 1'b0;
  assign load_err = 1'b0;
`endif

  always_comb begin
    nstate    = state;
    nib_ready = 1'b0;
    unique case (state)
      IDLE: if (load_start) nstate = HI;
      HI: begin
        nib_ready = 1'b1;
        if (xfer) nstate = LO;
      end
      LO: begin
        nib_ready = 1'b1;
        if (xfer) nstate = WR;
      end
      WR: begin
        if (!last) nstate = HI;
`ifdef TINY_LOADER_CHECKSUM_EN
        else nstate = CK;
`else
        else nstate = DN;
`endif
      end
      CK: begin
`ifdef TINY_LOADER_CHECKSUM_EN
        nib_ready = 1'b1;
        if (xfer && ck_last) nstate = DN;
`else
        nstate = IDLE;
`endif
      end
      DN:      nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  assign load_done = (state == DN);
  assign load_busy = (state != IDLE);
  assign cpu_hold  = load_busy;

  tiny_prog_ram #(
    .ADDR_W(ADDR_W)
  ) u_ram (
    .clock   (clock),
    .reset_n (reset_n),
    .we      (state == WR),
    .waddr   (addr),
    .wdata   ({hi, lo}),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

endmodule
